// File: rtl/pwm_cfg_ctrl.sv
// Complementary PWM pair with period-boundary shadow commit, dead-time insertion
// and sticky fault shutdown, configured through a small register port.
module pwm_cfg_ctrl #(
  parameter int unsigned CNT_W = 27,
  parameter int unsigned DT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  input  logic             fault,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic             period_tick,
  output logic             upd_pending,
  output logic             fault_latched
);

  localparam logic [1:0]  ADDR_PERIOD  = 2'd0;
  localparam logic [1:0]  ADDR_DUTY    = 2'd1;
  localparam logic [1:0]  ADDR_DT      = 2'd2;
  localparam logic [1:0]  ADDR_CTRL    = 2'd3;
  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_CLR_BIT = 2;

  logic [CNT_W-1:0] sh_period, sh_duty, act_period, act_duty, cnt;
  logic [DT_W-1:0]  sh_dt, act_dt, dead;
  logic             enable, enable_q, ref_q;

  logic [CNT_W-1:0] sh_period_nxt, sh_duty_nxt, act_period_nxt, act_duty_nxt, cnt_nxt;
  logic [DT_W-1:0]  sh_dt_nxt, act_dt_nxt, dead_nxt, dead_eff;
  logic             enable_nxt, fault_nxt, upd_nxt, tick_nxt, pwm_h_nxt, pwm_l_nxt;
  logic             ctrl_wr, shadow_wr, commit, running, ref_now, ref_edge;

  // Next-state: config shadowing/commit, counter, dead-time and fault handling
  always_comb begin
    ctrl_wr   = cfg_we && (cfg_addr == ADDR_CTRL);
    shadow_wr = cfg_we && (cfg_addr != ADDR_CTRL);
    commit    = !enable || period_tick;

    sh_period_nxt = sh_period;
    sh_duty_nxt   = sh_duty;
    sh_dt_nxt     = sh_dt;
    if (cfg_we && (cfg_addr == ADDR_PERIOD)) sh_period_nxt = cfg_wdata;
    if (cfg_we && (cfg_addr == ADDR_DUTY))   sh_duty_nxt   = cfg_wdata;
    if (cfg_we && (cfg_addr == ADDR_DT))     sh_dt_nxt     = cfg_wdata[DT_W-1:0];

    // Commit takes the shadow as it stood before this cycle's write
    act_period_nxt = commit ? sh_period : act_period;
    act_duty_nxt   = commit ? sh_duty   : act_duty;
    act_dt_nxt     = commit ? sh_dt     : act_dt;

    if (shadow_wr)   upd_nxt = 1'b1;
    else if (commit) upd_nxt = 1'b0;
    else             upd_nxt = upd_pending;

    // Fault wins over both a simultaneous clear and an enable write
    if (fault)                         enable_nxt = 1'b0;
    else if (ctrl_wr && !fault_latched) enable_nxt = cfg_wdata[CTRL_EN_BIT];
    else                               enable_nxt = enable;

    if (fault)                                  fault_nxt = 1'b1;
    else if (ctrl_wr && cfg_wdata[CTRL_CLR_BIT]) fault_nxt = 1'b0;
    else                                        fault_nxt = fault_latched;

    running  = enable && enable_nxt;
    ref_now  = (cnt < act_duty);
    ref_edge = enable && (!enable_q || (ref_now != ref_q));

    if (ref_edge)          dead_eff = act_dt;
    else if (dead != '0)   dead_eff = dead - DT_W'(1);
    else                   dead_eff = '0;

    dead_nxt  = running ? dead_eff : '0;
    pwm_h_nxt = running && (dead_eff == '0) && ref_now;
    pwm_l_nxt = running && (dead_eff == '0) && !ref_now;

    cnt_nxt  = (running && !period_tick && (act_period != '0)) ? cnt + CNT_W'(1) : '0;
    tick_nxt = enable_nxt && (act_period_nxt != '0) &&
               (cnt_nxt == act_period_nxt - CNT_W'(1));
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_period     <= '0;
      sh_duty       <= '0;
      sh_dt         <= '0;
      act_period    <= '0;
      act_duty      <= '0;
      act_dt        <= '0;
      cnt           <= '0;
      dead          <= '0;
      enable        <= 1'b0;
      enable_q      <= 1'b0;
      ref_q         <= 1'b0;
      pwm_h         <= 1'b0;
      pwm_l         <= 1'b0;
      period_tick   <= 1'b0;
      upd_pending   <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      sh_period     <= sh_period_nxt;
      sh_duty       <= sh_duty_nxt;
      sh_dt         <= sh_dt_nxt;
      act_period    <= act_period_nxt;
      act_duty      <= act_duty_nxt;
      act_dt        <= act_dt_nxt;
      cnt           <= cnt_nxt;
      dead          <= dead_nxt;
      enable        <= enable_nxt;
      enable_q      <= enable;
      ref_q         <= ref_now;
      pwm_h         <= pwm_h_nxt;
      pwm_l         <= pwm_l_nxt;
      period_tick   <= tick_nxt;
      upd_pending   <= upd_nxt;
      fault_latched <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_cfg_ctrl.sv
// Self-checking bench for pwm_cfg_ctrl: config table, hand-written corner
// sequences and random traffic against a cycle-level reference model.
module tb_pwm_cfg_ctrl;
  localparam int unsigned CNT_W = 27;
  localparam int unsigned DT_W  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_wdata;
  logic             fault;
  logic             pwm_h, pwm_l, period_tick, upd_pending, fault_latched;

  int n_cmp = 0;
  int n_bad = 0;

  pwm_cfg_ctrl #(.CNT_W(CNT_W), .DT_W(DT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .fault(fault), .pwm_h(pwm_h), .pwm_l(pwm_l), .period_tick(period_tick),
    .upd_pending(upd_pending), .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference model: outputs follow ref once dt cycles have elapsed since the
  // last ref edge (or enable), using the dead time in force at that edge.
  logic [CNT_W-1:0] m_sp = '0, m_sd = '0, m_ap = '0, m_ad = '0, m_cnt = '0;
  logic [DT_W-1:0]  m_sdt = '0, m_adt = '0;
  bit  m_en = 0, m_en_prev = 0, m_ref_prev = 0, m_upd = 0, m_flt = 0;
  bit  m_h = 0, m_l = 0, m_tick = 0;
  int  m_age = 0, m_edge_dt = 0;

  initial forever begin : model
    bit ref_now, tick_now, commit_m, en_n, run, ctrl_w, sh_w, live;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_sp = '0; m_sd = '0; m_sdt = '0; m_ap = '0; m_ad = '0; m_adt = '0; m_cnt = '0;
      m_en = 0; m_en_prev = 0; m_ref_prev = 0; m_upd = 0; m_flt = 0;
      m_h = 0; m_l = 0; m_tick = 0; m_age = 0; m_edge_dt = 0;
    end else begin
      ref_now  = (m_cnt < m_ad);
      tick_now = m_en && (m_ap != 0) && (m_cnt == m_ap - 1);
      commit_m = !m_en || tick_now;
      ctrl_w   = cfg_we && (cfg_addr == 2'd3);
      sh_w     = cfg_we && (cfg_addr != 2'd3);
      en_n     = fault ? 1'b0 : ((ctrl_w && !m_flt) ? cfg_wdata[0] : m_en);
      run      = m_en && en_n;
      if (m_en && (!m_en_prev || ref_now != m_ref_prev)) begin
        m_age = 0;
        m_edge_dt = int'(m_adt);
      end else if (m_age < 1000) begin
        m_age++;
      end
      live = run && (m_age >= m_edge_dt);
      m_h  = live && ref_now;
      m_l  = live && !ref_now;
      m_cnt = (run && !tick_now && m_ap != 0) ? m_cnt + 1'b1 : '0;
      if (commit_m) begin
        m_ap = m_sp; m_ad = m_sd; m_adt = m_sdt;
      end
      if (cfg_we && cfg_addr == 2'd0) m_sp  = cfg_wdata;
      if (cfg_we && cfg_addr == 2'd1) m_sd  = cfg_wdata;
      if (cfg_we && cfg_addr == 2'd2) m_sdt = cfg_wdata[DT_W-1:0];
      m_upd = sh_w ? 1'b1 : (commit_m ? 1'b0 : m_upd);
      m_flt = fault ? 1'b1 : ((ctrl_w && cfg_wdata[2]) ? 1'b0 : m_flt);
      m_ref_prev = ref_now;
      m_en_prev  = m_en;
      m_en       = en_n;
      m_tick     = m_en && (m_ap != 0) && (m_cnt == m_ap - 1);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("model_pwm_h", pwm_h, m_h);
      chk("model_pwm_l", pwm_l, m_l);
      chk("model_period_tick", period_tick, m_tick);
      chk("model_upd_pending", upd_pending, m_upd);
      chk("model_fault_latched", fault_latched, m_flt);
      chk("no_overlap", pwm_h & pwm_l, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [1:0] a, input int unsigned d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = CNT_W'(d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 40);
    chk(name, period_tick, 1);
  endtask

  typedef struct {
    int unsigned period, duty, dt, exp_h, exp_l;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int unsigned nh, nl, nt, n;
    logic en_b, clr_b;
    vecs[0] = '{10, 4,  2, 2,  4};
    vecs[1] = '{10, 0,  0, 0,  10};
    vecs[2] = '{10, 12, 0, 10, 0};
    vecs[3] = '{10, 4,  5, 0,  1};
    vecs[4] = '{10, 7,  2, 5,  1};
    vecs[5] = '{5,  2,  0, 2,  3};
    vecs[6] = '{1,  1,  0, 1,  0};
    vecs[7] = '{8,  3,  3, 0,  2};

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; fault = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pwm_h", pwm_h, 0);
    chk("rst_pwm_l", pwm_l, 0);
    chk("rst_tick", period_tick, 0);
    chk("rst_upd", upd_pending, 0);
    chk("rst_fault", fault_latched, 0);

    // Steady-state per-period high counts for each configuration
    for (int v = 0; v < 8; v++) begin
      wr(2'd3, 0);
      wr(2'd0, vecs[v].period);
      wr(2'd1, vecs[v].duty);
      wr(2'd2, vecs[v].dt);
      @(negedge clk);
      wr(2'd3, 1);
      repeat (2 * vecs[v].period + 3) @(negedge clk);
      nh = 0; nl = 0; nt = 0;
      repeat (3 * vecs[v].period) begin
        @(negedge clk);
        nh += 32'(pwm_h); nl += 32'(pwm_l); nt += 32'(period_tick);
      end
      chk($sformatf("vec%0d_h_cycles", v), nh, 3 * vecs[v].exp_h);
      chk($sformatf("vec%0d_l_cycles", v), nl, 3 * vecs[v].exp_l);
      chk($sformatf("vec%0d_ticks", v), nt, 3);
    end

    // Duty write three cycles before a tick, then one coincident with a tick
    wr(2'd3, 0); wr(2'd0, 10); wr(2'd1, 4); wr(2'd2, 2); @(negedge clk); wr(2'd3, 1);
    wait_tick("b_tick0");
    repeat (7) @(negedge clk);
    wr(2'd1, 7);
    chk("b_upd_after_write", upd_pending, 1);
    repeat (2) @(negedge clk);
    chk("b_tick_aligned", period_tick, 1);
    chk("b_upd_at_tick", upd_pending, 1);
    nh = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) chk("b_upd_after_tick", upd_pending, 0);
      nh += 32'(pwm_h);
    end
    chk("b_duty7_h", nh, 5);
    chk("b_tick2", period_tick, 1);
    wr(2'd1, 3);
    chk("b_coincident_upd", upd_pending, 1);
    nh = 32'(pwm_h);
    repeat (9) begin
      @(negedge clk);
      nh += 32'(pwm_h);
    end
    chk("b_delayed_h", nh, 5);
    chk("b_delayed_upd", upd_pending, 1);
    chk("b_tick3", period_tick, 1);
    nh = 0;
    repeat (10) begin
      @(negedge clk);
      nh += 32'(pwm_h);
    end
    chk("b_duty3_h", nh, 1);
    chk("b_committed_upd", upd_pending, 0);

    // Fault in the high phase, ignored enable, clear priority, restart
    repeat (4) @(negedge clk);
    chk("c_pre_fault_h", pwm_h, 1);
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    chk("c_fault_h", pwm_h, 0);
    chk("c_fault_l", pwm_l, 0);
    chk("c_fault_latched", fault_latched, 1);
    wr(2'd3, 1);
    n = 0;
    repeat (15) begin
      @(negedge clk);
      n += 32'(pwm_h) + 32'(pwm_l) + 32'(period_tick);
    end
    chk("c_enable_ignored", n, 0);
    fault = 1'b1;
    wr(2'd3, 4);
    fault = 1'b0;
    chk("c_clear_vs_fault", fault_latched, 1);
    wr(2'd3, 4);
    chk("c_clear", fault_latched, 0);
    wr(2'd3, 1);
    n = 0;
    while (!period_tick && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("c_restart_first_tick", n, 9);

    // Random traffic with an asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        cfg_we = 1'b0; fault = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("d_async_pwm_h", pwm_h, 0);
        chk("d_async_pwm_l", pwm_l, 0);
        chk("d_async_tick", period_tick, 0);
        chk("d_async_upd", upd_pending, 0);
        chk("d_async_fault", fault_latched, 0);
        @(negedge clk);
        rst = 1'b0;
      end
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_addr = 2'($urandom_range(0, 3));
      case (cfg_addr)
        2'd0: cfg_wdata = CNT_W'($urandom_range(0, 14));
        2'd1: cfg_wdata = CNT_W'($urandom_range(0, 16));
        2'd2: cfg_wdata = CNT_W'($urandom_range(0, 6));
        default: begin
          en_b  = ($urandom_range(0, 7) != 0);
          clr_b = ($urandom_range(0, 3) == 0);
          cfg_wdata = CNT_W'({clr_b, 1'b0, en_b});
        end
      endcase
      fault = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    cfg_we = 1'b0; fault = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
